// File: rtl/pc_fetch_gen_if.sv
// rtl/pc_fetch_gen_if.sv - instruction-fetch request handshake between the PC generator and instruction memory
interface pc_fetch_gen_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;

    modport master (output req_valid, output addr, input req_ready);
    modport slave  (input req_valid, input addr, output req_ready);
endinterface

// File: rtl/pc_fetch_gen.sv
// rtl/pc_fetch_gen.sv - fetch PC generator with redirect/stall handling; optional fetch counter under PC_FETCH_CNT_EN
module pc_fetch_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    pc_fetch_gen_if.master  imem,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_err
`ifdef PC_FETCH_CNT_EN
    ,
    output logic [31:0]     fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            req_valid;
    logic            accept;

    assign accept         = req_valid & imem.req_ready;
    assign imem.req_valid = req_valid;
    assign imem.addr      = pc;
    assign pc_plus4       = pc + 32'd4;

    // Redirect outranks everything; a pending request may only change address through it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            req_valid    <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            if (redirect_target[1:0] == 2'b00) begin
                pc           <= redirect_target;
                state        <= stall ? HOLD : RUN;
                req_valid    <= ~stall;
                misalign_err <= 1'b0;
            end else begin
                state        <= TRAP;
                req_valid    <= 1'b0;
                misalign_err <= 1'b1;
            end
        end else begin
            case (state)
                BOOT: begin
                    state     <= stall ? HOLD : RUN;
                    req_valid <= ~stall;
                end
                RUN: begin
                    if (accept) begin
                        pc        <= pc_plus4;
                        state     <= stall ? HOLD : RUN;
                        req_valid <= ~stall;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state     <= RUN;
                        req_valid <= 1'b1;
                    end
                end
                TRAP: begin
                    req_valid    <= 1'b0;
                    misalign_err <= 1'b1;
                end
                default: begin
                    state     <= BOOT;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
        end else if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb/tb_pc_fetch_gen.sv - directed vector bench for pc_fetch_gen, plus reset and wrap-around sequences
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic        rst2_n;
    logic [31:0] pc_plus4_2;
    logic        misalign_err_2;
`ifdef PC_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] fetch_cnt_2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_gen_if imem_if ();
    pc_fetch_gen_if imem2_if ();

    pc_fetch_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (imem_if.master),
        .pc_plus4        (pc_plus4),
        .misalign_err    (misalign_err)
`ifdef PC_FETCH_CNT_EN
        ,
        .fetch_cnt       (fetch_cnt)
`endif
    );

    pc_fetch_gen #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
        .clk             (clk),
        .rst_n           (rst2_n),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .imem            (imem2_if.master),
        .pc_plus4        (pc_plus4_2),
        .misalign_err    (misalign_err_2)
`ifdef PC_FETCH_CNT_EN
        ,
        .fetch_cnt       (fetch_cnt_2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        ready;
        logic        ev;
        logic [31:0] ea;
        logic        ee;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    initial begin
        // inputs applied this cycle | outputs expected before this cycle's edge
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h80,  1'b1, 1'b1, 32'h4,   1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h80,  1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h82,  1'b0, 1'b1, 32'h84,  1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h84,  1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h84,  1'b1};
        tbl[14] = '{1'b0, 1'b1, 32'h10,  1'b0, 1'b1, 32'h100, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b0};
        tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b0};
        tbl[18] = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h14,  1'b0};
        tbl[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0};

        rst_n             = 1'b0;
        rst2_n            = 1'b0;
        stall             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_target   = 32'h0;
        imem_if.req_ready = 1'b1;
        imem2_if.req_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_valid", {31'b0, imem_if.req_valid}, 32'h0);
        check("reset_addr", imem_if.addr, 32'h0);
        check("reset_err", {31'b0, misalign_err}, 32'h0);
`ifdef PC_FETCH_CNT_EN
        check("reset_cnt", fetch_cnt, 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            check($sformatf("v%0d_valid", i), {31'b0, imem_if.req_valid}, {31'b0, tbl[i].ev});
            check($sformatf("v%0d_addr", i), imem_if.addr, tbl[i].ea);
            check($sformatf("v%0d_plus4", i), pc_plus4, tbl[i].ea + 32'd4);
            check($sformatf("v%0d_err", i), {31'b0, misalign_err}, {31'b0, tbl[i].ee});
            stall             = tbl[i].stall;
            redirect_valid    = tbl[i].rv;
            redirect_target   = tbl[i].rt;
            imem_if.req_ready = tbl[i].ready;
            @(negedge clk);
        end

        check("pending_valid", {31'b0, imem_if.req_valid}, 32'h1);
        check("pending_addr", imem_if.addr, 32'h204);
`ifdef PC_FETCH_CNT_EN
        check("cnt_accepts", fetch_cnt, 32'd9);
`endif
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, imem_if.req_valid}, 32'h0);
        check("async_rst_addr", imem_if.addr, 32'h0);
`ifdef PC_FETCH_CNT_EN
        check("async_rst_cnt", fetch_cnt, 32'h0);
`endif

        @(negedge clk);
        rst2_n = 1'b1;
        check("wrap_boot_valid", {31'b0, imem2_if.req_valid}, 32'h0);
        check("wrap_boot_addr", imem2_if.addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check("wrap_a0_valid", {31'b0, imem2_if.req_valid}, 32'h1);
        check("wrap_a0_addr", imem2_if.addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check("wrap_a1_addr", imem2_if.addr, 32'hFFFF_FFFC);
        check("wrap_a1_plus4", pc_plus4_2, 32'h0);
        @(negedge clk);
        check("wrap_a2_addr", imem2_if.addr, 32'h0);
        check("wrap_a2_plus4", pc_plus4_2, 32'h4);
        check("wrap_err", {31'b0, misalign_err_2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
